// File: rtl/load_store_unit.sv
// Load/store unit: accepts one four-phase load or store request, performs a
// single word-aligned memory access with lane steering, and returns the
// extended load result. Optional macro MISALIGN_CHECK_EN enables misaligned
// access detection (misaligned accesses then skip memory and flag misalign).
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ld,
  input  logic              req_st,
  output logic              ack_ld,
  output logic              ack_st,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              misalign
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                is_ld_q, is_ld_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ack_ld_q, ack_ld_d;
  logic                ack_st_q, ack_st_d;
  logic                misalign_q, misalign_d;

  logic [3:0]          be_in;
  logic [31:0]         wdata_rep;
  logic                mis_in;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_ext;

  // Lane steering of the incoming request; funct3[1:0] of 1x is a word.
  always_comb begin
    be_in     = 4'b1111;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_in     = 4'b0001 << addr[1:0];
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_in     = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  // Halfwords need an even address, words a 4-byte aligned one.
  always_comb begin
    mis_in = 1'b0;
    if (funct3[1:0] == 2'b01)
      mis_in = addr[0];
    else if (funct3[1] == 1'b1)
      mis_in = (addr[1:0] != 2'b00);
  end
`else
  assign mis_in = 1'b0;
`endif

  // Extract and extend the load result using the captured size and offset.
  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q[1:0])
      2'b00:   ld_ext = funct3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = funct3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic of the IDLE/ACCESS/DONE FSM.
  always_comb begin
    state_d     = state_q;
    is_ld_d     = is_ld_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ack_ld_d    = ack_ld_q;
    ack_st_d    = ack_st_q;
    misalign_d  = misalign_q;
    case (state_q)
      IDLE: begin
        if (req_ld ^ req_st) begin
          is_ld_d  = req_ld;
          funct3_d = funct3;
          off_d    = addr[1:0];
          if (mis_in) begin
            // Misaligned: complete at once without touching memory.
            state_d    = DONE;
            ack_ld_d   = req_ld;
            ack_st_d   = req_st;
            misalign_d = 1'b1;
            rdata_d    = 32'h0;
          end else begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_st;
            mem_be_d    = be_in;
            mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = wdata_rep;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (is_ld_q) begin
            ack_ld_d = 1'b1;
            rdata_d  = ld_ext;
          end else begin
            ack_st_d = 1'b1;
            rdata_d  = 32'h0;
          end
        end
      end
      DONE: begin
        if (is_ld_q ? !req_ld : !req_st) begin
          state_d    = IDLE;
          ack_ld_d   = 1'b0;
          ack_st_d   = 1'b0;
          misalign_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      is_ld_q     <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      ack_ld_q    <= 1'b0;
      ack_st_q    <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_ld_q     <= is_ld_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ack_ld_q    <= ack_ld_d;
      ack_st_q    <= ack_st_d;
      misalign_q  <= misalign_d;
    end
  end

  assign ack_ld    = ack_ld_q;
  assign ack_st    = ack_st_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign misalign  = misalign_q;

endmodule
